// File: rtl/booth_mult8.sv
// Sequential 8x8 signed radix-2 Booth multiplier, one Booth step per cycle through a single ripple adder.
// Define BOOTH_MULT8_ACC_EN to add the acc_en port (multiply-accumulate into p).

module booth_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [8:0] s
);
  // Both operands are sign-extended to 9 bits, so s is the exact signed sum.
  logic [8:0] ae;
  logic [8:0] be;
  logic       carry;

  always_comb begin
    ae    = {a[7], a};
    be    = {b[7], b};
    carry = ci;
    s     = '0;
    for (int i = 0; i < 9; i++) begin
      s[i]  = ae[i] ^ be[i] ^ carry;
      carry = (ae[i] & be[i]) | (carry & (ae[i] ^ be[i]));
    end
  end
endmodule

module booth_mult8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
`ifdef BOOTH_MULT8_ACC_EN
  input  logic        acc_en,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);
  // Handshake: start is accepted only in IDLE or DONE; busy is high for the
  // eight RUN cycles; done pulses for one cycle with p valid in the same cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic        q1_q, q1_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;
  logic        acc_en_q, acc_en_d;
  logic        acc_en_in;

  logic [7:0]  add_b;
  logic        add_ci;
  logic [8:0]  sum;
  logic [15:0] product;

`ifdef BOOTH_MULT8_ACC_EN
  assign acc_en_in = acc_en;
`else
  assign acc_en_in = 1'b0;
`endif

  booth_add8 u_add (
    .a  (acc_q),
    .b  (add_b),
    .ci (add_ci),
    .s  (sum)
  );

  // The final step's shifted result is the full product: {sum[8:1], sum[0], q[7:1]}.
  assign product = {sum, q_q[7:1]};

  always_comb begin
    add_b  = 8'h00;
    add_ci = 1'b0;
    case ({q_q[0], q1_q})
      2'b01:   add_b = m_q;
      2'b10: begin
        add_b  = ~m_q;
        add_ci = 1'b1;
      end
      default: add_b = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    acc_en_d = acc_en_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_RUN;
          m_d      = a;
          q_d      = b;
          acc_d    = 8'h00;
          q1_d     = 1'b0;
          cnt_d    = 3'd0;
          acc_en_d = acc_en_in;
        end
      end
      ST_RUN: begin
        acc_d = sum[8:1];
        q_d   = {sum[0], q_q[7:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
          p_d     = acc_en_q ? (p_q + product) : product;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
      acc_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      acc_en_q <= acc_en_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign p    = p_q;
endmodule

// File: tb/tb_booth_mult8.sv
// Randomized self-checking bench for booth_mult8 against a plain signed-multiply model.
// Define BOOTH_MULT8_ACC_EN to also exercise the multiply-accumulate build.

module tb_booth_mult8;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        acc_en;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_p = 16'h0000;

  booth_mult8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (op_a),
    .b      (op_b),
`ifdef BOOTH_MULT8_ACC_EN
    .acc_en (acc_en),
`endif
    .busy   (busy),
    .done   (done),
    .p      (p)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // reference model: plain signed multiply, optional 16-bit wrapping accumulate
  function automatic logic [15:0] model_op(input logic [7:0] ta, input logic [7:0] tb_v,
                                           input logic ten);
    int prod;
    logic [15:0] r;
    prod = $signed(ta) * $signed(tb_v);
    r = prod[15:0];
`ifdef BOOTH_MULT8_ACC_EN
    if (ten) r = model_p + r;
`endif
    return r;
  endfunction

  // Issue from IDLE or DONE; returns right after the DONE edge.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ten,
                       input bit inj);
    model_p = model_op(ta, tb_v, ten);
    exp_q.push_back(model_p);
    op_a = ta; op_b = tb_v; acc_en = ten; start = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("busy_run", {15'd0, busy}, 16'd1);
      check("done_run", {15'd0, done}, 16'd0);
      if (inj && i == 3) begin
        op_a = 8'($urandom); op_b = 8'($urandom); acc_en = 1'($urandom); start = 1'b1;
      end else start = 1'b0;
      step();
    end
    start = 1'b0;
    check("done_pulse", {15'd0, done}, 16'd1);
    check("busy_done", {15'd0, busy}, 16'd0);
    check("product", p, exp_q.pop_front());
  endtask

  task automatic go_idle();
    step();
    check("idle_busy", {15'd0, busy}, 16'd0);
    check("idle_done", {15'd0, done}, 16'd0);
    check("idle_hold", p, model_p);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; acc_en = 1'b0;
    step(); step();
    check("rst_p", p, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    rst_n = 1'b1;
    go_idle();

    // directed
    do_op(8'd3, 8'd5, 1'b0, 0);
    check("p_3x5", p, 16'h000F);
    go_idle();
    do_op(8'h80, 8'h80, 1'b0, 0);
    check("p_m128sq", p, 16'h4000);
    go_idle();
    do_op(8'hFF, 8'd127, 1'b0, 0);
    check("p_m1x127", p, 16'hFF81);
    go_idle();
    do_op(8'd127, 8'h80, 1'b0, 0);
    check("p_127xm128", p, 16'hC080);
    go_idle();

    // start mid-run ignored, then back-to-back from DONE
    do_op(8'd7, 8'hF9, 1'b0, 1);
    do_op(8'd2, 8'hFE, 1'b0, 0);
    check("p_b2b", p, 16'hFFFC);
    go_idle();

    // mid-run reset
    op_a = 8'd9; op_b = 8'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_p = 16'h0000;
    check("mrst_p", p, 16'h0000);
    check("mrst_busy", {15'd0, busy}, 16'd0);
    check("mrst_done", {15'd0, done}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("mrst_nodone", {15'd0, done}, 16'd0);
    end

`ifdef BOOTH_MULT8_ACC_EN
    do_op(8'd10, 8'd10, 1'b0, 0);
    check("mac_100", p, 16'h0064);
    go_idle();
    do_op(8'hFD, 8'd4, 1'b1, 0);
    check("mac_88", p, 16'h0058);
    go_idle();
    do_op(8'h80, 8'h80, 1'b0, 0);
    do_op(8'd127, 8'd127, 1'b1, 0);
    do_op(8'd127, 8'd2, 1'b1, 0);
    check("mac_7fff", p, 16'h7FFF);
    do_op(8'd1, 8'd1, 1'b1, 0);
    check("mac_wrap", p, 16'h8000);
    go_idle();
`endif

    // randomized: mixed idle gaps, back-to-back issues and ignored mid-run starts
    for (int n = 0; n < 60; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
